inst_encoder: RTL

Sequential MIPS instruction encoder and program writer, the encode-side counterpart of the ID-stage decoder. It accepts one symbolic instruction per valid/ready handshake, a mnemonic code plus register, shift, immediate and target fields. It packs them into the 32-bit MIPS word the decoder accepts and writes that word into instruction memory at an auto-incrementing word address. It loads test and boot programs into the pipelined CPU's instruction memory and flags mnemonics it cannot encode.

---
 rtl/inst_encoder.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: packs symbolic MIPS instruction fields into 32-bit words
// and writes them to instruction memory at an auto-incrementing address.
// One instruction per three cycles: accept (IDLE), encode (ENCODE),
// write strobe (WRITE). Unknown mnemonics raise a sticky err flag and
// skip the write.
module inst_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err,
  output logic              wrapped,
  input  logic              clear
);

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    WRITE
  } state_t;

  // Mnemonic codes presented on in_mnem
  localparam logic [5:0] MN_NOP     = 6'd0;
  localparam logic [5:0] MN_ADD     = 6'd1;
  localparam logic [5:0] MN_ADDU    = 6'd2;
  localparam logic [5:0] MN_SUB     = 6'd3;
  localparam logic [5:0] MN_SUBU    = 6'd4;
  localparam logic [5:0] MN_SLT     = 6'd5;
  localparam logic [5:0] MN_AND     = 6'd6;
  localparam logic [5:0] MN_OR      = 6'd7;
  localparam logic [5:0] MN_XOR     = 6'd8;
  localparam logic [5:0] MN_NOR     = 6'd9;
  localparam logic [5:0] MN_SRL     = 6'd10;
  localparam logic [5:0] MN_SLL     = 6'd11;
  localparam logic [5:0] MN_JR      = 6'd12;
  localparam logic [5:0] MN_JALR    = 6'd13;
  localparam logic [5:0] MN_SYSCALL = 6'd14;
  localparam logic [5:0] MN_MFHI    = 6'd15;
  localparam logic [5:0] MN_MFLO    = 6'd16;
  localparam logic [5:0] MN_LW      = 6'd17;
  localparam logic [5:0] MN_SW      = 6'd18;
  localparam logic [5:0] MN_ADDI    = 6'd19;
  localparam logic [5:0] MN_ADDIU   = 6'd20;
  localparam logic [5:0] MN_ANDI    = 6'd21;
  localparam logic [5:0] MN_ORI     = 6'd22;
  localparam logic [5:0] MN_XORI    = 6'd23;
  localparam logic [5:0] MN_SLTI    = 6'd24;
  localparam logic [5:0] MN_LUI     = 6'd25;
  localparam logic [5:0] MN_BEQ     = 6'd26;
  localparam logic [5:0] MN_BNE     = 6'd27;
  localparam logic [5:0] MN_J       = 6'd28;
  localparam logic [5:0] MN_JAL     = 6'd29;
  localparam logic [5:0] MN_ERET    = 6'd30;
  localparam logic [5:0] MN_MFC0    = 6'd31;
  localparam logic [5:0] MN_MTC0    = 6'd32;
  localparam logic [5:0] MN_MUL     = 6'd33;

  // Opcodes
  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_COP0     = 6'h10;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SW       = 6'h2B;

  // Function codes
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_MUL     = 6'h02;

  localparam logic [4:0] RA_REG     = 5'd31;
  localparam logic [4:0] COP0_MF    = 5'b00000;
  localparam logic [4:0] COP0_MT    = 5'b00100;
  localparam logic [31:0] WORD_ERET = 32'h4200_0018;

  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_next;
  logic   accept;

  logic [5:0]        f_mnem;
  logic [4:0]        f_rs;
  logic [4:0]        f_rt;
  logic [4:0]        f_rd;
  logic [4:0]        f_shamt;
  logic [15:0]       f_imm;
  logic [25:0]       f_target;

  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word;
  logic [31:0]       enc_word;
  logic              enc_known;
  logic              err_set;
  logic              wrap_set;

  function automatic logic [31:0] r_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] shamt, input logic [5:0] funct);
    return {op, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_type(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

  // Encoder: packs the captured fields; fields a format does not use are forced to zero
  always_comb begin
    enc_word  = 32'h0000_0000;
    enc_known = 1'b1;
    case (f_mnem)
      MN_NOP:     enc_word = 32'h0000_0000;
      MN_ADD:     enc_word = r_type(OP_SPECIAL, f_rs, f_rt, f_rd, 5'd0, FN_ADD);
      MN_ADDU:    enc_word = r_type(OP_SPECIAL, f_rs, f_rt, f_rd, 5'd0, FN_ADDU);
      MN_SUB:     enc_word = r_type(OP_SPECIAL, f_rs, f_rt, f_rd, 5'd0, FN_SUB);
      MN_SUBU:    enc_word = r_type(OP_SPECIAL, f_rs, f_rt, f_rd, 5'd0, FN_SUBU);
      MN_SLT:     enc_word = r_type(OP_SPECIAL, f_rs, f_rt, f_rd, 5'd0, FN_SLT);
      MN_AND:     enc_word = r_type(OP_SPECIAL, f_rs, f_rt, f_rd, 5'd0, FN_AND);
      MN_OR:      enc_word = r_type(OP_SPECIAL, f_rs, f_rt, f_rd, 5'd0, FN_OR);
      MN_XOR:     enc_word = r_type(OP_SPECIAL, f_rs, f_rt, f_rd, 5'd0, FN_XOR);
      MN_NOR:     enc_word = r_type(OP_SPECIAL, f_rs, f_rt, f_rd, 5'd0, FN_NOR);
      MN_SRL:     enc_word = r_type(OP_SPECIAL, 5'd0, f_rt, f_rd, f_shamt, FN_SRL);
      MN_SLL:     enc_word = r_type(OP_SPECIAL, 5'd0, f_rt, f_rd, f_shamt, FN_SLL);
      MN_JR:      enc_word = r_type(OP_SPECIAL, f_rs, 5'd0, 5'd0, 5'd0, FN_JR);
      MN_JALR:    enc_word = r_type(OP_SPECIAL, f_rs, 5'd0, RA_REG, 5'd0, FN_JALR);
      MN_SYSCALL: enc_word = r_type(OP_SPECIAL, 5'd0, 5'd0, 5'd0, 5'd0, FN_SYSCALL);
      MN_MFHI:    enc_word = r_type(OP_SPECIAL, 5'd0, 5'd0, f_rd, 5'd0, FN_MFHI);
      MN_MFLO:    enc_word = r_type(OP_SPECIAL, 5'd0, 5'd0, f_rd, 5'd0, FN_MFLO);
      MN_LW:      enc_word = i_type(OP_LW, f_rs, f_rt, f_imm);
      MN_SW:      enc_word = i_type(OP_SW, f_rs, f_rt, f_imm);
      MN_ADDI:    enc_word = i_type(OP_ADDI, f_rs, f_rt, f_imm);
      MN_ADDIU:   enc_word = i_type(OP_ADDIU, f_rs, f_rt, f_imm);
      MN_ANDI:    enc_word = i_type(OP_ANDI, f_rs, f_rt, f_imm);
      MN_ORI:     enc_word = i_type(OP_ORI, f_rs, f_rt, f_imm);
      MN_XORI:    enc_word = i_type(OP_XORI, f_rs, f_rt, f_imm);
      MN_SLTI:    enc_word = i_type(OP_SLTI, f_rs, f_rt, f_imm);
      MN_LUI:     enc_word = i_type(OP_LUI, 5'd0, f_rt, f_imm);
      MN_BEQ:     enc_word = i_type(OP_BEQ, f_rs, f_rt, f_imm);
      MN_BNE:     enc_word = i_type(OP_BNE, f_rs, f_rt, f_imm);
      MN_J:       enc_word = j_type(OP_J, f_target);
      MN_JAL:     enc_word = j_type(OP_JAL, f_target);
      MN_ERET:    enc_word = WORD_ERET;
      MN_MFC0:    enc_word = {OP_COP0, COP0_MF, f_rt, f_rd, 11'd0};
      MN_MTC0:    enc_word = {OP_COP0, COP0_MT, f_rt, f_rd, 11'd0};
      MN_MUL:     enc_word = r_type(OP_SPECIAL2, f_rs, f_rt, f_rd, 5'd0, FN_MUL);
      default: begin
        enc_word  = 32'h0000_0000;
        enc_known = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; base_load blocks an accept in the same cycle
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && !base_load) begin
          accept     = 1'b1;
          state_next = ENCODE;
        end
      end
      ENCODE: begin
        state_next = enc_known ? WRITE : IDLE;
      end
      WRITE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the instruction fields on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_mnem   <= 6'd0;
      f_rs     <= 5'd0;
      f_rt     <= 5'd0;
      f_rd     <= 5'd0;
      f_shamt  <= 5'd0;
      f_imm    <= 16'd0;
      f_target <= 26'd0;
    end else if (accept) begin
      f_mnem   <= in_mnem;
      f_rs     <= in_rs;
      f_rt     <= in_rt;
      f_rd     <= in_rd;
      f_shamt  <= in_shamt;
      f_imm    <= in_imm;
      f_target <= in_target;
    end
  end

  // Write pointer: loadable in IDLE, advances (modulo) after each write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (state == IDLE && base_load) begin
      ptr <= base_addr;
    end else if (state == WRITE) begin
      ptr <= ptr + PTR_ONE;
    end
  end

  // Encoded word register, held stable through the write cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= 32'h0000_0000;
    end else if (state == ENCODE && enc_known) begin
      word <= enc_word;
    end
  end

  assign err_set  = (state == ENCODE) && !enc_known;
  assign wrap_set = (state == WRITE) && (&ptr);

  // Sticky status flags; a set event beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err     <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      err     <= err_set  | (err & ~clear);
      wrapped <= wrap_set | (wrapped & ~clear);
    end
  end

  assign in_ready   = (state == IDLE) && !base_load && !rst;
  assign imem_we    = (state == WRITE);
  assign imem_addr  = ptr;
  assign imem_wdata = word;

endmodule
